// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmitter and receiver: character
// format levels, the baud divisor helper and the transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // System clocks per serial bit; integer divide, the remainder is dropped.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a fall-through read port.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // Flags are registered, so a push while full is refused even if a pop lands on the same edge.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, LSB first, fed from a small byte FIFO.
// Frames drain back-to-back with no idle gap while the FIFO has data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned STOP_W       = 2;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP   = STOP_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ / BAUD must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [STOP_W-1:0]    stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 baud_done;
  logic                 pop_c;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (i_valid),
    .pop       (pop_c),
    .wr_data   (i_data),
    .rd_data_c (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_ready   = !fifo_full;
  assign o_busy    = (state != IDLE) || !fifo_empty;
  assign baud_done = (baud_cnt == '0);

  // A new byte is taken from idle, or at the end of the final stop bit so frames abut.
  always_comb begin
    pop_c = 1'b0;
    case (state)
      IDLE:    pop_c = !fifo_empty;
      STOP:    pop_c = baud_done && (stop_cnt >= LAST_STOP) && !fifo_empty;
      default: pop_c = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_tx     <= IDLE_LEVEL;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_c) begin
            shift    <= fifo_head;
            o_tx     <= START_LEVEL;
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
          end else begin
            o_tx <= IDLE_LEVEL;
          end
        end

        START: begin
          if (baud_done) begin
            o_tx     <= shift[0];
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        // shift[0] is always the bit currently on the line.
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx < LAST_IDX) begin
              shift   <= shift >> 1;
              o_tx    <= shift[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end else begin
              o_tx     <= STOP_LEVEL;
              stop_cnt <= '0;
              state    <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_done) begin
            if (stop_cnt < LAST_STOP) begin
              stop_cnt <= stop_cnt + STOP_W'(1);
              baud_cnt <= BAUD_RELOAD;
            end else if (pop_c) begin
              shift    <= fifo_head;
              o_tx     <= START_LEVEL;
              baud_cnt <= BAUD_RELOAD;
              state    <= START;
            end else begin
              o_tx  <= IDLE_LEVEL;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        default: begin
          o_tx  <= IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit: single frames from a table,
// then back-to-back, burst/full, mid-frame reset and two-stop-bit sequences.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, ready2;
  logic       tx1, tx2;
  logic       busy1, busy2;

  int n_cmp;
  int n_bad;
  int cyc;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // line[0] = start bit, line[8:1] = data LSB first, line[9] = stop
  } vec_t;

  vec_t       vec [4];
  logic [9:0] bline [6];
  int         k, guard, t0, t_rdy, t_acc6;
  logic       r;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .o_tx(tx1), .o_busy(busy1)
  );

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_valid(valid2),
    .o_ready(ready2), .o_tx(tx2), .o_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tx_of(input int which);
    return (which != 0) ? tx2 : tx1;
  endfunction

  function automatic logic busy_of(input int which);
    return (which != 0) ? busy2 : busy1;
  endfunction

  // Call right after the edge that starts the start bit; returns one frame period later.
  task automatic check_frame(input int which, input logic [9:0] line, input int stops,
                             input string name);
    logic exp_bit;
    for (int b = 0; b < 9 + stops; b++) begin
      if (b < 10) exp_bit = line[b];
      else        exp_bit = 1'b1;
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("%s bit%0d cyc%0d tx", name, b, c), 32'(tx_of(which)), 32'(exp_bit));
        if (b == 8 + stops && c == 9)
          chk($sformatf("%s busy in last stop", name), 32'(busy_of(which)), 32'd1);
        tick();
      end
    end
  endtask

  task automatic push1(input logic [7:0] d, input string name);
    valid1 = 1'b1;
    data1  = d;
    chk($sformatf("%s ready before push", name), 32'(ready1), 32'd1);
    tick();
    valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data1 = 8'h00; data2 = 8'h00;

    vec[0] = '{8'h55, 10'b1010101010};
    vec[1] = '{8'hA3, 10'b1101000110};
    vec[2] = '{8'h3C, 10'b1001111000};
    vec[3] = '{8'h81, 10'b1100000010};
    bline[0] = 10'b1000100000;
    bline[1] = 10'b1000100010;
    bline[2] = 10'b1000100100;
    bline[3] = 10'b1000100110;
    bline[4] = 10'b1000101000;
    bline[5] = 10'b1000101010;

    // Reset state
    #3;
    chk("reset tx1", 32'(tx1), 32'd1);
    chk("reset busy1", 32'(busy1), 32'd0);
    chk("reset ready1", 32'(ready1), 32'd1);
    chk("reset tx2", 32'(tx2), 32'd1);
    chk("reset busy2", 32'(busy2), 32'd0);
    #9 rst = 1'b0;
    tick();

    // Single frames from the table
    for (int i = 0; i < 4; i++) begin
      push1(vec[i].data, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d busy after accept", i), 32'(busy1), 32'd1);
      chk($sformatf("vec%0d tx still idle", i), 32'(tx1), 32'd1);
      tick();
      check_frame(0, vec[i].line, 1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d busy after frame", i), 32'(busy1), 32'd0);
      chk($sformatf("vec%0d tx idle after frame", i), 32'(tx1), 32'd1);
      tick();
    end

    // Back-to-back 0x41 then 0x61, no gap
    valid1 = 1'b1; data1 = 8'h41;
    tick();
    data1 = 8'h61;
    tick();
    valid1 = 1'b0;
    check_frame(0, 10'b1010000010, 1, "b2b 41");
    check_frame(0, 10'b1011000010, 1, "b2b 61");
    chk("b2b busy after", 32'(busy1), 32'd0);
    chk("b2b tx after", 32'(tx1), 32'd1);
    tick();

    // Burst of six with valid held; covers full-with-pop refusal
    valid1 = 1'b1; data1 = 8'h10;
    t_rdy = 0; t_acc6 = 0; guard = 0;
    chk("burst ready at start", 32'(ready1), 32'd1);
    tick();
    k = 1; t0 = cyc;
    fork
      begin
        data1 = 8'h11;
        while (k < 6 && guard < 400) begin
          r = ready1;
          tick();
          guard++;
          if (r) begin
            k++;
            if (k == 5) chk("burst ready after 5th accept", 32'(ready1), 32'd0);
            if (k == 6) t_acc6 = cyc;
            if (k < 6) data1 = 8'h10 + 8'(k);
          end else if (t_rdy == 0 && ready1) begin
            t_rdy = cyc;
          end
        end
        valid1 = 1'b0;
        chk("burst accepted count", 32'(k), 32'd6);
      end
      begin
        tick();
        for (int i = 0; i < 6; i++)
          check_frame(0, bline[i], 1, $sformatf("burst%0d", i));
      end
    join
    chk("full+pop refused, ready returns", 32'(t_rdy - t0), 32'd101);
    chk("sixth accepted after pop", 32'(t_acc6 - t0), 32'd102);
    chk("burst busy after", 32'(busy1), 32'd0);
    tick();

    // Reset mid-DATA with two bytes queued
    valid1 = 1'b1; data1 = 8'hA3;
    tick();
    data1 = 8'h11;
    tick();
    data1 = 8'h22;
    tick();
    valid1 = 1'b0;
    repeat (34) tick();
    chk("pre-reset tx (0xA3 bit2)", 32'(tx1), 32'd0);
    chk("pre-reset busy", 32'(busy1), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset tx", 32'(tx1), 32'd1);
    chk("async reset busy", 32'(busy1), 32'd0);
    chk("async reset ready", 32'(ready1), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk($sformatf("post-reset idle tx c%0d", i), 32'(tx1), 32'd1);
      chk($sformatf("post-reset idle busy c%0d", i), 32'(busy1), 32'd0);
    end
    push1(8'h3C, "after reset");
    tick();
    check_frame(0, 10'b1001111000, 1, "after reset 3C");
    chk("after reset busy", 32'(busy1), 32'd0);

    // Two stop bits: 0xFF then 0x00, 110-cycle period
    valid2 = 1'b1; data2 = 8'hFF;
    chk("stop2 ready", 32'(ready2), 32'd1);
    tick();
    data2 = 8'h00;
    tick();
    valid2 = 1'b0;
    check_frame(1, 10'b1111111110, 2, "stop2 FF");
    check_frame(1, 10'b1000000000, 2, "stop2 00");
    chk("stop2 busy after", 32'(busy2), 32'd0);
    chk("stop2 tx after", 32'(tx2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
